// File: rtl/spi_reg_bank.sv
// ============================================================================
// Module   : spi_reg_bank
// Purpose  : Byte-level command decoder and register file behind a mode-0
//            SPI slave byte engine. A command byte (R/W flag + 7-bit address)
//            is followed by burst data bytes with address auto-increment.
// Ports    : clk       - system clock (same clock as the SPI slave)
//            reset     - asynchronous active-high reset
//            SPI_CS    - raw active-low chip select pin (synchronized here)
//            rx_dv     - one-clk pulse, received byte valid
//            rx_byte   - received byte
//            tx_byte   - next byte the slave shifts out on MISO
//            regs_out  - flattened register file, reg k at [8k+7:8k]
//            wr_strobe - one-clk pulse on a register write
//            wr_addr   - address of the last write
//            busy      - transaction in progress (state not IDLE)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_bank #(
  parameter int          NREGS      = 16,
  parameter logic [7:0]  ID_BYTE    = 8'hA5,
  parameter int          CMD_RD_BIT = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SPI_CS,
  input  logic                 rx_dv,
  input  logic [7:0]           rx_byte,
  output logic [7:0]           tx_byte,
  output logic [8*NREGS-1:0]   regs_out,
  output logic                 wr_strobe,
  output logic [6:0]           wr_addr,
  output logic                 busy
);

  localparam logic [7:0] NREGS_B = 8'(NREGS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic        rd_q, rd_d;
  logic [7:0]  tx_q, tx_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  regs_q [NREGS];
  logic [7:0]  regs_d [NREGS];

  // Chip-select synchronizer plus one delay flop for edge detection. The
  // chain resets to 1 (deselected) so reset release alone is not an edge.
  logic cs_meta_q, cs_s_q, cs_prev_q;
  logic cs_fall, cs_rise;

  assign cs_fall = cs_prev_q & ~cs_s_q;
  assign cs_rise = ~cs_prev_q & cs_s_q;

  // Read map: in-range registers, the ID byte at the top address, else zero.
  function automatic logic [7:0] rdata(input logic [6:0] a,
                                       input logic [7:0] r [NREGS]);
    logic [7:0] v;
    v = (a == 7'h7F) ? ID_BYTE : 8'h00;
    for (int k = 0; k < NREGS; k++) begin
      if (a == k[6:0]) v = r[k];
    end
    return v;
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    tx_d        = tx_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    regs_d      = regs_q;

    case (state_q)
      ST_IDLE: begin
        tx_d = ID_BYTE;
      end
      ST_CMD: begin
        if (rx_dv) begin
          addr_d  = rx_byte[6:0];
          rd_d    = rx_byte[CMD_RD_BIT];
          state_d = ST_DATA;
          tx_d    = rx_byte[CMD_RD_BIT] ? rdata(rx_byte[6:0], regs_q) : 8'h00;
        end
      end
      ST_DATA: begin
        if (rx_dv) begin
          addr_d = addr_q + 7'd1;
          if (rd_q) begin
            tx_d = rdata(addr_q + 7'd1, regs_q);
          end else begin
            tx_d = 8'h00;
            // Writes beyond the register file are silently dropped.
            if ({1'b0, addr_q} < NREGS_B) begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
            end
            for (int k = 0; k < NREGS; k++) begin
              if (addr_q == k[6:0]) regs_d[k] = rx_byte;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Chip-select edges override the state/address/tx decisions above but
    // leave the register update alone, so a byte landing in the same cycle
    // as deselect still commits.
    if (cs_rise) begin
      state_d = ST_IDLE;
      addr_d  = 7'd0;
      tx_d    = ID_BYTE;
    end else if (cs_fall) begin
      state_d = ST_CMD;
      addr_d  = 7'd0;
      tx_d    = ID_BYTE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_meta_q   <= 1'b1;
      cs_s_q      <= 1'b1;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      addr_q      <= 7'd0;
      rd_q        <= 1'b0;
      tx_q        <= ID_BYTE;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 7'd0;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= 8'h00;
    end else begin
      cs_meta_q   <= SPI_CS;
      cs_s_q      <= cs_meta_q;
      cs_prev_q   <= cs_s_q;
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      tx_q        <= tx_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      regs_q      <= regs_d;
    end
  end

  assign tx_byte   = tx_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign busy      = (state_q != ST_IDLE);

  for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
    assign regs_out[8*g +: 8] = regs_q[g];
  end

endmodule

`default_nettype wire

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Byte-level command decoder and register file that sits directly downstream of the mode-0 SPI slave byte engine.
- Consumes the slave's receive-valid pulse and received byte, and drives the slave's transmit byte.
- Implements a register protocol: a command byte (R/W flag and 7-bit address) followed by burst data bytes with address auto-increment.
- Exposes the register contents and a write strobe to the rest of the chip.

Parameters:
- NREGS, 16: number of 8-bit RW registers at addresses 0..NREGS-1. Legal range 1..127.
- ID_BYTE, 8'hA5: value returned on MISO during the command byte, and on reads of address 7'h7F.
- CMD_RD_BIT, 7: bit of the command byte that selects read (1) or write (0).

Ports:
- clk, input, 1: system clock, same clock as the SPI slave.
- reset, input, 1: asynchronous reset, active-high.
- SPI_CS, input, 1: raw chip-select pin, active-low. Synchronized internally.
- rx_dv, input, 1: one-clk pulse from the SPI slave, asserted when a byte is received.
- rx_byte, input, 8: received byte from the SPI slave. Valid when rx_dv=1.
- tx_byte, output, 8: byte the SPI slave shifts out next (feeds its Tx_Byte).
- regs_out, output, 8*NREGS: flattened register file. Register k occupies bits [8k+7:8k].
- wr_strobe, output, 1: one-clk pulse when a register is written.
- wr_addr, output, 7: address of the last write. Valid with wr_strobe.
- busy, output, 1: high while a transaction is in progress (state other than IDLE).

Behaviour:
- Reset values: all registers 0; tx_byte=ID_BYTE; wr_strobe=0; wr_addr=0; busy=0; state=IDLE; addr=0.
- Chip select: SPI_CS passes through a 2-flop synchronizer, giving cs_s. A falling edge of cs_s is cs_fall; a rising edge is cs_rise.
- IDLE:
  - tx_byte=ID_BYTE.
  - cs_fall -> CMD.
  - rx_dv in IDLE is ignored.
- CMD, on rx_dv:
  - addr <= rx_byte[6:0]; rd <= rx_byte[CMD_RD_BIT]; next state DATA.
  - Read: tx_byte <= rdata(rx_byte[6:0]) on the following clk edge (1-cycle latency after rx_dv).
  - Write: tx_byte <= 8'h00.
- DATA, on rx_dv, write transaction:
  - If addr < NREGS: reg[addr] <= rx_byte; wr_strobe=1 for exactly one cycle; wr_addr <= addr.
  - If addr >= NREGS: the write is dropped and wr_strobe stays 0.
  - addr <= addr+1; tx_byte stays 8'h00.
- DATA, on rx_dv, read transaction:
  - addr <= addr+1; tx_byte <= rdata(addr+1), 1-cycle latency. rx_byte is ignored.
- rdata(a) read map:
  - a < NREGS: reg[a].
  - a == 7'h7F: ID_BYTE.
  - Otherwise: 8'h00.
- Address wrap: addr is 7 bits and wraps 7'h7F -> 7'h00. The first byte after the wrap targets register 0.
- Latency budget: tx_byte must be stable within 2 clk after rx_dv. With clk/SPI_Clk >= 8 this lands before the slave's load window closes, so the next byte shifted out is correct.
- Any state, cs_rise: -> IDLE; tx_byte <= ID_BYTE; addr <= 0. A partial byte has no effect.
- Simultaneous rx_dv and cs_rise in the same cycle: the byte is processed first (a write commits, a command is decoded), then the state goes to IDLE. Net result: the register is written and the state is IDLE.
- cs_fall while not IDLE (glitch or re-select): restart in CMD; addr <= 0; tx_byte <= ID_BYTE.
- Reset mid-transaction: everything returns to its reset value immediately, including registers already written.
- The state machine is a single process on posedge clk / posedge reset. regs_out is driven directly from the register flops (no combinational path from rx_byte).

Test Plan:
- Write burst: CS low, bytes 0x02, 0x11, 0x22, 0x33, CS high -> reg2=0x11, reg3=0x22, reg4=0x33; three wr_strobe pulses with wr_addr 2, 3, 4; busy returns to 0.
- Read burst: preload reg5=0x5A and reg6=0xC3; CS low, bytes 0x85, 0x00, 0x00 -> MISO bytes are 0xA5 (command byte), 0x5A, 0xC3; no wr_strobe.
- Out-of-range and ID: write 0x20, 0xFF with NREGS=16 -> no strobe, regs_out unchanged. Read 0xFF -> data byte 0xA5, and the next byte wraps to reg0.
- Wrap: write command 0x0F, data 0xAA, 0xBB -> reg15=0xAA; addresses 0x10..0x7E drop writes. A burst reaching 0x7F then 0x00 writes reg0.
- CS abort: CS high after the command byte plus 4 SPI clocks of data -> no register change, tx_byte=0xA5. The next transaction decodes normally.
- Reset mid-burst: assert reset after 0x01, 0x77 -> regs_out all 0, tx_byte=0xA5, busy=0. After reset deasserts, a fresh write to reg1 succeeds.
